apb_arb2: RTL and testbench

- Two-master, one-slave APB arbiter and sequencer.
- Shares the register-debugger APB slave between the I2C-to-APB bridge (master 0) and a second on-chip requester (master 1, e.g. a UART or scan bridge).
- Holds the losing master in wait states until it is granted, then replays that master's transfer to the slave.
- Sits between both bridges and the debugger; it is the only driver of the slave-side APB signals.

---
 rtl/apb_arb_pkg.sv | 18 +
 rtl/apb_arb_rr2.sv | 21 ++
 rtl/apb_arb2.sv | 158 +++++++++++++++
 tb/tb_apb_arb2.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and constants for the two-master APB arbiter.
//   arb_state_t        : arbiter FSM states (IDLE, SETUP, ACCESS)
//   ARB_ADDR_W/DATA_W  : default APB address/data widths
//   ARB_TIMEOUT_RDATA  : read data returned to a master on a forced completion
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_t;

    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 8;

    localparam logic [7:0] ARB_TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/apb_arb_rr2.sv
// apb_arb_rr2: combinational 2-way round-robin picker.
//   req[1:0]   : request per master
//   last_grant : master served by the last completed transfer
//   gnt        : index of the winning master (meaningful when valid=1)
//   valid      : at least one master is requesting
module apb_arb_rr2
    import apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt,
    output logic       valid
);

    // On a tie the master that was not served last wins; otherwise the sole requester.
    always_comb begin
        valid = |req;
        gnt   = &req ? ~last_grant : req[1];
    end

endmodule

// File: rtl/apb_arb2.sv
// apb_arb2: two-master, one-slave APB arbiter and sequencer.
// Master 0 (I2C-to-APB bridge) and master 1 (second on-chip requester) share one
// APB slave. The winner's request is snapshotted in IDLE and replayed to the slave
// as SETUP then ACCESS; the other master is held in wait states until granted.
//   clk, rst_n                   : clock, synchronous active-low reset
//   m0_* / m1_*                  : master-side APB (psel, penable, pwrite, paddr,
//                                  pwdata in; prdata, pready out)
//   s_*                          : slave-side APB (psel, penable, pwrite, paddr,
//                                  pwdata out; prdata, pready in)
//   grant                        : owning master, valid while busy
//   busy                         : high in SETUP or ACCESS
//   timeout                      : one-cycle pulse on a forced completion
// Optional macro APB_ARB_TIMEOUT_EN: force-completes an ACCESS after TIMEOUT
// slave wait cycles; without it ACCESS waits indefinitely and timeout is 0.
module apb_arb2
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [DATA_W-1:0] s_pwdata,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    output logic              grant,
    output logic              busy,
    output logic              timeout
);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rr_gnt, rr_valid;
    logic              acc, to_hit, done;
    logic              m0_penable_unused, m1_penable_unused;

    // penable is not needed to arbitrate: psel alone is the request in either phase.
    assign m0_penable_unused = m0_penable;
    assign m1_penable_unused = m1_penable;

    apb_arb_rr2 u_rr (
        .req        ({m1_psel, m0_psel}),
        .last_grant (last_grant_q),
        .gnt        (rr_gnt),
        .valid      (rr_valid)
    );

    assign acc = (state_q == ACCESS);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter restarts every time ACCESS is entered and only counts stalled cycles.
    always_comb begin
        cnt_d = (state_q == SETUP) ? '0 : (acc && !s_pready) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign to_hit = acc && !s_pready && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    // TIMEOUT only sizes the wait counter, which does not exist in this build.
    assign unused_timeout = |TIMEOUT;
    assign to_hit         = 1'b0;
`endif

    assign done = acc && (s_pready || to_hit);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        if (state_q == IDLE && rr_valid) begin
            // The snapshot is taken only here, so later master-side changes are ignored.
            state_d = SETUP;
            grant_d = rr_gnt;
            addr_d  = rr_gnt ? m1_paddr  : m0_paddr;
            write_d = rr_gnt ? m1_pwrite : m0_pwrite;
            wdata_d = rr_gnt ? m1_pwdata : m0_pwdata;
        end else if (state_q == SETUP) begin
            state_d = ACCESS;
        end else if (done) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
        end
    end

    // Slave side is driven only while busy; a forced completion drops psel/penable.
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;
    assign timeout   = to_hit;
    assign s_psel    = busy && !to_hit;
    assign s_penable = acc && !to_hit;
    assign s_paddr   = busy ? addr_q  : '0;
    assign s_pwrite  = busy && write_q;
    assign s_pwdata  = busy ? wdata_q : '0;

    // Ready and read data pass straight through to the granted master only.
    assign m0_pready = acc && !grant_q && (s_pready || to_hit);
    assign m1_pready = acc &&  grant_q && (s_pready || to_hit);
    assign m0_prdata = (acc && !grant_q) ? (to_hit ? DATA_W'(ARB_TIMEOUT_RDATA) : s_prdata) : '0;
    assign m1_prdata = (acc &&  grant_q) ? (to_hit ? DATA_W'(ARB_TIMEOUT_RDATA) : s_prdata) : '0;

endmodule

// File: tb/tb_apb_arb2.sv
// tb_apb_arb2: directed self-checking bench for apb_arb2 with a simple slave model.
module tb_apb_arb2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite;
    logic [7:0] m0_paddr, m0_pwdata, m0_prdata, m1_paddr, m1_pwdata, m1_prdata;
    logic       m0_pready, m1_pready;
    logic       s_psel, s_penable, s_pwrite, s_pready;
    logic [7:0] s_paddr, s_pwdata, s_prdata;
    logic       grant, busy, timeout;

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wdata;
        int         t;
    } xfer_t;

    xfer_t      log_q[$];
    xfer_t      ent;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         wcnt = 0;
    int         slave_wait = 0;
    logic       slave_hang = 1'b0;
    logic [7:0] slave_rdata = 8'h00;
    int         p0 = 0, p1 = 0, tos = 0;

    always #5 clk = ~clk;

    apb_arb2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_psel    (m0_psel),
        .m0_penable (m0_penable),
        .m0_pwrite  (m0_pwrite),
        .m0_paddr   (m0_paddr),
        .m0_pwdata  (m0_pwdata),
        .m0_prdata  (m0_prdata),
        .m0_pready  (m0_pready),
        .m1_psel    (m1_psel),
        .m1_penable (m1_penable),
        .m1_pwrite  (m1_pwrite),
        .m1_paddr   (m1_paddr),
        .m1_pwdata  (m1_pwdata),
        .m1_prdata  (m1_prdata),
        .m1_pready  (m1_pready),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_pwrite   (s_pwrite),
        .s_paddr    (s_paddr),
        .s_pwdata   (s_pwdata),
        .s_prdata   (s_prdata),
        .s_pready   (s_pready),
        .grant      (grant),
        .busy       (busy),
        .timeout    (timeout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: pready after slave_wait stalled ACCESS cycles, never while hung.
    always @(posedge clk) wcnt <= (s_psel && s_penable && !s_pready) ? wcnt + 1 : 0;
    assign s_pready = !slave_hang && (wcnt >= slave_wait);
    assign s_prdata = slave_rdata;

    always @(negedge clk) begin
        if (rst_n && s_psel && s_penable && s_pready) begin
            ent.addr  = s_paddr;
            ent.wr    = s_pwrite;
            ent.wdata = s_pwdata;
            ent.t     = cyc;
            log_q.push_back(ent);
        end
        if (m0_pready) p0++;
        if (m1_pready) p1++;
        if (timeout) tos++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit m, input logic sel, input logic en, input logic [7:0] a,
                         input logic w, input logic [7:0] d);
        if (m) begin
            m1_psel = sel; m1_penable = en; m1_paddr = a; m1_pwrite = w; m1_pwdata = d;
        end else begin
            m0_psel = sel; m0_penable = en; m0_paddr = a; m0_pwrite = w; m0_pwdata = d;
        end
    endtask

    task automatic xfer(input bit m, input logic [7:0] a, input logic w, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
        int t0 = cyc;
        int n = 0;
        drive(m, 1'b1, 1'b0, a, w, d);
        step();
        drive(m, 1'b1, 1'b1, a, w, d);
        #1;
        while (!(m ? m1_pready : m0_pready) && n < 200) begin
            step();
            #1;
            n++;
        end
        chk("xfer_wait_bound", 32'(n < 200), 32'd1);
        rd  = m ? m1_prdata : m0_prdata;
        lat = cyc - t0;
        step();
        drive(m, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd0, rd1;
        int         l0, l1, ps0, ps1, ts;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_ctrl", {s_psel, s_penable, s_pwrite, busy, grant, m0_pready, m1_pready, timeout}, 0);
        chk("reset_bus", {s_paddr, s_pwdata, m0_prdata, m1_prdata}, 0);
        rst_n = 1'b1;
        step();

        // Single zero-wait write from m0
        drive(1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 8'hA5);
        #1;
        chk("wr_idle_psel", s_psel, 0);
        step();
        chk("wr_setup_psel", s_psel, 1);
        chk("wr_setup_penable", s_penable, 0);
        chk("wr_setup_paddr", s_paddr, 8'h05);
        chk("wr_setup_pwdata", s_pwdata, 8'hA5);
        chk("wr_setup_pwrite", s_pwrite, 1);
        chk("wr_setup_busy_grant", {busy, grant}, 2'b10);
        chk("wr_setup_m0_pready", m0_pready, 0);
        drive(1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 8'hA5);
        step();
        chk("wr_access_penable", s_penable, 1);
        chk("wr_access_m0_pready", m0_pready, 1);
        chk("wr_access_m1_pready", m1_pready, 0);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("wr_done_idle", {busy, s_psel, s_penable}, 0);
        chk("wr_done_paddr", s_paddr, 0);
        chk("wr_log_count", log_q.size(), 1);
        log_q.delete();

        // m1 read with three slave wait states
        slave_wait  = 3;
        slave_rdata = 8'h3C;
        ps0 = p0;
        ps1 = p1;
        xfer(1'b1, 8'h10, 1'b0, 8'h00, rd1, l1);
        chk("rd_prdata", rd1, 8'h3C);
        chk("rd_latency", l1, 5);
        chk("rd_m1_pready_once", p1 - ps1, 1);
        chk("rd_m0_pready_none", p0 - ps0, 0);
        chk("rd_slave_addr", log_q[0].addr, 8'h10);
        slave_wait = 0;

        // Contention right after reset: m0 first, then m1; second pair m0 first again
        do_reset();
        log_q.delete();
        fork
            xfer(1'b0, 8'h20, 1'b1, 8'h11, rd0, l0);
            xfer(1'b1, 8'h21, 1'b1, 8'h22, rd1, l1);
        join
        chk("cont1_count", log_q.size(), 2);
        chk("cont1_first", log_q[0].addr, 8'h20);
        chk("cont1_second", {log_q[1].addr, log_q[1].wdata}, 16'h2122);
        chk("cont1_lat_m0", l0, 2);
        chk("cont1_lat_m1", l1, 5);
        log_q.delete();
        fork
            xfer(1'b0, 8'h30, 1'b1, 8'h33, rd0, l0);
            xfer(1'b1, 8'h31, 1'b1, 8'h44, rd1, l1);
        join
        chk("cont2_first", log_q[0].addr, 8'h30);
        chk("cont2_second", log_q[1].addr, 8'h31);

        // Back-to-back writes from m0
        log_q.delete();
        xfer(1'b0, 8'h01, 1'b1, 8'hB1, rd0, l0);
        xfer(1'b0, 8'h02, 1'b1, 8'hB2, rd0, l0);
        xfer(1'b0, 8'h03, 1'b1, 8'hB3, rd0, l0);
        chk("b2b_count", log_q.size(), 3);
        chk("b2b_order", {log_q[0].addr, log_q[1].addr, log_q[2].addr}, 24'h010203);
        chk("b2b_wdata", log_q[2].wdata, 8'hB3);
        chk("b2b_gap1", log_q[1].t - log_q[0].t, 3);
        chk("b2b_gap2", log_q[2].t - log_q[1].t, 3);

        // Reset during an m1 ACCESS; m1 was due priority, reset hands it back to m0
        slave_hang = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 8'h00);
        step();
        drive(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
        step();
        chk("rst_mid_access", {s_psel, s_penable, grant, busy}, 4'b1111);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        chk("rst_mid_ctrl", {s_psel, s_penable, s_pwrite, busy, grant, m0_pready, m1_pready, timeout}, 0);
        chk("rst_mid_bus", {s_paddr, s_pwdata, m1_prdata}, 0);
        rst_n = 1'b1;
        slave_hang = 1'b0;
        step();
        log_q.delete();
        fork
            xfer(1'b0, 8'h50, 1'b1, 8'h55, rd0, l0);
            xfer(1'b1, 8'h51, 1'b1, 8'h66, rd1, l1);
        join
        chk("rst_after_first", log_q[0].addr, 8'h50);
        chk("rst_after_count", log_q.size(), 2);

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never readies: forced completion on the 16th ACCESS cycle
        slave_hang = 1'b1;
        ts = tos;
        xfer(1'b0, 8'h60, 1'b0, 8'h00, rd0, l0);
        chk("to_prdata", rd0, 8'hFF);
        chk("to_latency", l0, 17);
        chk("to_pulse_once", tos - ts, 1);
        slave_hang  = 1'b0;
        slave_rdata = 8'h5A;
        xfer(1'b0, 8'h61, 1'b0, 8'h00, rd0, l0);
        chk("to_next_prdata", rd0, 8'h5A);
        chk("to_next_latency", l0, 2);
`else
        ts = 0;
        chk("no_timeout_pulse", tos - ts, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
